// File: rtl/vote_session_if.sv
// vote_session_if: bundles the member-vote inputs and the session status
// outputs of vote_session_ctrl. The master side (button/debounce logic or a
// bench) drives start and the vote pulses; the slave side (the controller)
// drives everything else. All slave outputs are registered in the controller.
interface vote_session_if #(
    parameter int CNT_W = 10
) ();
    logic             start;
    logic [3:0]       vote_yes;
    logic [3:0]       vote_no;
    logic             busy;
    logic [CNT_W-1:0] remain;
    logic [3:0]       voted_mask;
    logic [3:0]       yes_mask;
    logic             result_valid;
    logic             pass;

    modport master (
        output start, vote_yes, vote_no,
        input  busy, remain, voted_mask, yes_mask, result_valid, pass
    );

    modport slave (
        input  start, vote_yes, vote_no,
        output busy, remain, voted_mask, yes_mask, result_valid, pass
    );
endinterface

// File: rtl/vote_session_ctrl.sv
// vote_session_ctrl: runs one four-member voting session at a time.
// IDLE -> (start) -> VOTE for WINDOW cycles -> DONE (one cycle, verdict
// published with result_valid) -> IDLE. Each member's first unambiguous
// yes/no pulse inside the window is latched and then locked.
// Optional feature macro: VOTE_EARLY_CLOSE_EN -- when defined, the window
// closes as soon as all four members have voted.
// Pulses on start/vote_* are plain level-sampled strobes (no handshake);
// every output is a register or a decode of the state register only.
module vote_session_ctrl #(
    parameter int WINDOW = 1000,
    parameter int CNT_W  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    vote_session_if.slave bus,
    output logic [1:0] o_dbg_state
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_VOTE = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // WINDOW = 2^CNT_W truncates to 0; counting down from 0 through the
    // wrap to 1 still yields exactly 2^CNT_W accepting cycles.
    localparam logic [CNT_W-1:0] LP_LOAD = CNT_W'(WINDOW);
    localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_remain;
    logic [3:0]       r_voted;
    logic [3:0]       r_yes;
    logic             r_pass;
    logic             r_valid;

    logic [3:0]       w_take;
    logic [3:0]       w_voted_nxt;
    logic [3:0]       w_yes_nxt;
    logic             w_close;

    function automatic logic majority3of4(input logic [3:0] m);
        majority3of4 = (m[0] & m[1] & m[2]) | (m[0] & m[1] & m[3]) |
                       (m[0] & m[2] & m[3]) | (m[1] & m[2] & m[3]);
    endfunction

    // Accept a member's vote only if still unvoted and exactly one of yes/no is high.
    always_comb begin
        w_take      = ~r_voted & (bus.vote_yes ^ bus.vote_no);
        w_voted_nxt = r_voted | w_take;
        w_yes_nxt   = r_yes | (w_take & bus.vote_yes);
`ifdef VOTE_EARLY_CLOSE_EN
        w_close     = (r_remain == LP_ONE) || (w_voted_nxt == 4'hF);
`else
        w_close     = (r_remain == LP_ONE);
`endif
    end

    // Session FSM, countdown, vote latches and registered verdict.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_remain <= '0;
            r_voted  <= 4'h0;
            r_yes    <= 4'h0;
            r_pass   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state  <= ST_VOTE;
                        r_remain <= LP_LOAD;
                        r_voted  <= 4'h0;
                        r_yes    <= 4'h0;
                        r_pass   <= 1'b0;
                    end
                end
                ST_VOTE: begin
                    r_voted <= w_voted_nxt;
                    r_yes   <= w_yes_nxt;
                    if (w_close) begin
                        r_state  <= ST_DONE;
                        r_remain <= '0;
                        r_pass   <= majority3of4(w_yes_nxt);
                        r_valid  <= 1'b1;
                    end else begin
                        r_remain <= r_remain - LP_ONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = (r_state == ST_VOTE);
    assign bus.remain       = r_remain;
    assign bus.voted_mask   = r_voted;
    assign bus.yes_mask     = r_yes;
    assign bus.result_valid = r_valid;
    assign bus.pass         = r_pass;
    assign o_dbg_state      = r_state;
endmodule

// File: doc/vote_session_ctrl.md
# vote_session_ctrl

- Sequences a four-member voting session around the 3-of-4 majority voter.
- Opens a timed voting window on `start` and latches each member's first yes/no vote.
- Closes the window on timeout, or optionally early once all four have voted, then publishes a registered majority verdict with a one-cycle valid pulse.
- Sits between debounced member-button pulses and the display/indicator logic.

## Interface
Parameters:
- `WINDOW`, 1000: voting window length in clock cycles; legal range 1..2^`CNT_W`.
- `CNT_W`, 10: width of the window countdown and `remain` output.

Ports:
- `clk` input 1: system clock; all logic on rising edge.
- `rst_n` input 1: synchronous active-low reset; one clock, reset is synchronous and active-low.
- `start` input 1: single-cycle pulse; opens a session when idle.
- `vote_yes` input 4: per-member yes pulse, bit i = member i.
- `vote_no` input 4: per-member no pulse, bit i = member i.
- `busy` output 1: high while the window is open (state VOTE).
- `remain` output `CNT_W`: cycles left in the window including the current one; 0 outside VOTE.
- `voted_mask` output 4: members whose vote has been latched this session.
- `yes_mask` output 4: members who latched yes.
- `result_valid` output 1: one-cycle pulse when the verdict is published.
- `pass` output 1: verdict; 1 when at least 3 of 4 `yes_mask` bits are set; held until the next session opens.

## Operation
- States: IDLE, VOTE, DONE.
- IDLE: `start`=1 clears `voted_mask`, `yes_mask` and `pass`, loads `remain`=`WINDOW`, and moves to VOTE. Votes are ignored.
- VOTE, per member i, when `voted_mask[i]`=0:
  - `vote_yes[i]`=1 and `vote_no[i]`=0: set `voted_mask[i]` and `yes_mask[i]`.
  - `vote_no[i]`=1 and `vote_yes[i]`=0: set `voted_mask[i]` only.
  - Both high in the same cycle: ignored; the member stays unvoted.
  - Once voted, a member's vote is locked; further pulses from that member are ignored.
- VOTE countdown: `remain` decrements by 1 every cycle. The cycle with `remain`=1 is the last accepting cycle; then go to DONE.
- VOTE `start`: ignored.
- DONE, for exactly one cycle:
  - `result_valid`=1.
  - `pass` = majority(`yes_mask`) = a&b&c | a&b&d | a&c&d | b&c&d.
  - Then return to IDLE.
  - `start` in DONE is ignored.
- Members who have not voted count as no.
- `pass`, `yes_mask` and `voted_mask` hold their values in IDLE until the next accepted `start`.
- `rst_n`=0 in any state, including mid-window, gives: state IDLE, all outputs 0, `remain`=0. A session in progress is discarded and no `result_valid` pulse is issued.

## Timing
- `start` high in cycle N (state IDLE):
  - `busy`=1 and `remain`=`WINDOW` at cycle N+1.
  - Votes are accepted in cycles N+1..N+`WINDOW`.
  - `result_valid`=1 and `pass` valid at N+`WINDOW`+1.
  - `busy`=0 from N+`WINDOW`+1.
- A vote sampled in cycle K is visible on `voted_mask`/`yes_mask` at K+1.
- A vote arriving in the final accepting cycle counts.
- The earliest next session is a `start` in cycle N+`WINDOW`+2, the first IDLE cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `VOTE_EARLY_CLOSE_EN` defined:
  - In VOTE, if `voted_mask` including this cycle's accepted votes becomes 4'hF, the next state is DONE regardless of `remain`.
  - In that case `result_valid` rises the cycle after the fourth vote is accepted.
- `VOTE_EARLY_CLOSE_EN` undefined: the window always runs the full `WINDOW` cycles.

## Test plan
All scenarios use `WINDOW`=8.
- Reset: hold `rst_n`=0 for 2 cycles with random inputs. All outputs must be 0 in those cycles and stay 0 afterwards until `start`.
- Normal session:
  - Stimulus: `start` at cycle 0; `vote_yes`=4'b0111 at cycle 2; `vote_no`=4'b1000 at cycle 3.
  - Required: `result_valid`=1 only at cycle 9, `pass`=1, `yes_mask`=4'b0111, `voted_mask`=4'hF.
- Failing verdict and vote lock:
  - Stimulus: yes from members 0 and 1 at cycle 2; member 0 no at cycle 4; member 2 yes with no in the same cycle at cycle 5.
  - Required: `yes_mask`=4'b0011, `voted_mask`=4'b0011, `pass`=0 at cycle 9.
- Boundary:
  - Stimulus: vote from member 3 in cycle 8 (`remain`=1); `start` pulses at cycles 4 and 9.
  - Required: the cycle-8 vote is counted; both `start` pulses are ignored; a `start` at cycle 10 opens a new session and clears the masks at cycle 11.
- Reset mid-window: `rst_n`=0 at cycle 5 gives no `result_valid` pulse ever and all outputs 0 at cycle 6.
- Early close (only when `VOTE_EARLY_CLOSE_EN` is defined): all four members vote yes at cycle 3. Required: `result_valid`=1 at cycle 4 and `pass`=1. Without the macro the pulse stays at cycle 9.
